// File: rtl/pit_timer_if.sv
// Bus bundle between the I/O decoder and the programmable interval timer:
// write data and strobes, read enables, read-back data and the interrupt pulse.
interface pit_timer_if #(parameter int WIDTH = 16);
   logic [WIDTH-1:0] din;
   logic             pit0w;
   logic             pit1w;
   logic             pit0r;
   logic             pit1r;
   logic [WIDTH-1:0] dout;
   logic             douten;
   logic             tint;

   modport master (
      output din, pit0w, pit1w, pit0r, pit1r,
      input  dout, douten, tint
   );

   modport slave (
      input  din, pit0w, pit1w, pit0r, pit1r,
      output dout, douten, tint
   );
endinterface

// File: rtl/pit_timer.sv
// Programmable interval timer: a prescaler feeding a divider, with a one-clock
// interrupt on divider expiry and a coherent prescaler/divider read-back.
module pit_timer #(
   parameter int WIDTH = 16
) (
   input logic   clk,
   input logic   resetl,
   pit_timer_if.slave bus
);

   logic [WIDTH-1:0] pre_rld;
   logic [WIDTH-1:0] div_rld;
   logic [WIDTH-1:0] pre_cnt;
   logic [WIDTH-1:0] div_cnt;
   logic [WIDTH-1:0] div_hold;
   logic             hold_vld;
   logic             pit0r_d;
   logic             tint_q;

   logic             run;
   logic             wr_any;
   logic             rd_start;

   assign run      = (pre_rld != '0);
   assign wr_any   = bus.pit0w | bus.pit1w;
   assign rd_start = bus.pit0r & ~pit0r_d;

   // Writes reload both stages and take precedence over counting, which also
   // swallows any expiry that would have landed on the same edge.
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         pre_rld <= '0;
         div_rld <= '0;
         pre_cnt <= '0;
         div_cnt <= '0;
         tint_q  <= 1'b0;
      end else begin
         tint_q <= 1'b0;
         if (bus.pit0w && bus.pit1w) begin
            pre_rld <= bus.din;
            pre_cnt <= bus.din;
            div_rld <= bus.din;
            div_cnt <= bus.din;
         end else if (bus.pit0w) begin
            pre_rld <= bus.din;
            pre_cnt <= bus.din;
            div_cnt <= div_rld;
         end else if (bus.pit1w) begin
            div_rld <= bus.din;
            div_cnt <= bus.din;
            pre_cnt <= pre_rld;
         end else if (run) begin
            if (pre_cnt != '0) begin
               pre_cnt <= pre_cnt - WIDTH'(1);
            end else begin
               pre_cnt <= pre_rld;
               if (div_cnt != '0) begin
                  div_cnt <= div_cnt - WIDTH'(1);
               end else begin
                  div_cnt <= div_rld;
                  tint_q  <= 1'b1;
               end
            end
         end
      end
   end

   // Snapshot the divider at the start of a prescaler read so the following
   // divider read pairs with the prescaler value just returned.
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         pit0r_d  <= 1'b0;
         div_hold <= '0;
         hold_vld <= 1'b0;
      end else begin
         pit0r_d <= bus.pit0r;
         if (rd_start) begin
            div_hold <= div_cnt;
            hold_vld <= 1'b1;
         end else if (wr_any || (bus.pit1r && !bus.pit0r)) begin
            hold_vld <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.dout = '0;
      if (bus.pit0r) begin
         bus.dout = pre_cnt;
      end else if (bus.pit1r) begin
         bus.dout = hold_vld ? div_hold : div_cnt;
      end
   end

   assign bus.douten = bus.pit0r | bus.pit1r;
   assign bus.tint   = tint_q;

endmodule

// File: tb/tb_pit_timer.sv
// Directed bench for pit_timer: expected values are queued as stimulus is
// applied and popped when the matching output is sampled.
module tb_pit_timer;

   localparam int WIDTH = 16;

   typedef struct {
      string       tag;
      logic [31:0] value;
   } exp_t;

   logic  clk;
   logic  resetl;
   exp_t  exp_q[$];
   int    checks;
   int    errors;
   int    n;

   pit_timer_if #(.WIDTH(WIDTH)) bus ();

   pit_timer #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .resetl (resetl),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are always sampled 1 ns after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic w0, input logic w1, input logic r0,
                                input logic r1, input logic [WIDTH-1:0] d);
      bus.pit0w = w0;
      bus.pit1w = w1;
      bus.pit0r = r0;
      bus.pit1r = r1;
      bus.din   = d;
   endtask

   task automatic pushExpected(input string tag, input logic [31:0] value);
      exp_t e;
      e.tag   = tag;
      e.value = value;
      exp_q.push_back(e);
   endtask

   task automatic checkOutput(input logic [31:0] observed);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_empty observed=%0h required=entry", observed);
      end else begin
         e = exp_q.pop_front();
         assert (observed === e.value) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, observed, e.value);
         end
      end
   endtask

   task automatic writeReg(input logic w0, input logic w1, input logic [WIDTH-1:0] d);
      applyStimulus(w0, w1, 1'b0, 1'b0, d);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   // Ticks until tint is seen; an expired budget reports -1.
   task automatic waitTint(input int budget, output int cycles);
      cycles = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (bus.tint === 1'b1) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic countTints(input int len, output int pulses);
      pulses = 0;
      for (int i = 0; i < len; i++) begin
         tick();
         if (bus.tint !== 1'b0) pulses++;
      end
   endtask

   task automatic pulseReset();
      #1 resetl = 1'b0;
      #3 resetl = 1'b1;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      resetl = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
      repeat (3) tick();
      pushExpected("rst_dout", 32'h0);
      checkOutput({16'h0, bus.dout});
      pushExpected("rst_douten", 32'h0);
      checkOutput({31'h0, bus.douten});
      pushExpected("rst_tint", 32'h0);
      checkOutput({31'h0, bus.tint});
      @(negedge clk) resetl = 1'b1;
      tick();

      // pre_rld=5, div_rld=0: period 6, then reset while tint is high
      writeReg(1'b1, 1'b0, 16'd5);
      pushExpected("pre5_first_tint", 32'd6);
      waitTint(50, n);
      checkOutput(n);
      #1 resetl = 1'b0;
      #1;
      pushExpected("async_rst_tint", 32'h0);
      checkOutput({31'h0, bus.tint});
      pushExpected("async_rst_dout", 32'h0);
      checkOutput({16'h0, bus.dout});
      pushExpected("async_rst_douten", 32'h0);
      checkOutput({31'h0, bus.douten});
      @(negedge clk) resetl = 1'b1;
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
      #1;
      pushExpected("rst_pre_cnt", 32'h0);
      checkOutput({16'h0, bus.dout});
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
      pushExpected("idle_1000_pulses", 32'd0);
      countTints(1000, n);
      checkOutput(n);

      // Basic period: div=2, pre=1 -> 6 clocks
      writeReg(1'b0, 1'b1, 16'd2);
      writeReg(1'b1, 1'b0, 16'd1);
      pushExpected("basic_first_tint", 32'd6);
      waitTint(50, n);
      checkOutput(n);
      tick();
      pushExpected("basic_tint_width", 32'h0);
      checkOutput({31'h0, bus.tint});
      pushExpected("basic_second_tint", 32'd5);
      waitTint(50, n);
      checkOutput(n);
      pushExpected("basic_third_tint", 32'd6);
      waitTint(50, n);
      checkOutput(n);

      // Stopped timer: divider only, prescaler reload zero
      pulseReset();
      writeReg(1'b0, 1'b1, 16'd3);
      pushExpected("stopped_500_pulses", 32'd0);
      countTints(500, n);
      checkOutput(n);
      writeReg(1'b1, 1'b0, 16'h0003);
      pushExpected("pre3_div3_first", 32'd16);
      waitTint(100, n);
      checkOutput(n);
      pushExpected("pre3_div3_period", 32'd16);
      waitTint(100, n);
      checkOutput(n);

      // Restart on write
      writeReg(1'b0, 1'b1, 16'd2);
      writeReg(1'b1, 1'b0, 16'd1);
      pushExpected("restart_pre_tint", 32'd6);
      waitTint(50, n);
      checkOutput(n);
      repeat (4) tick();
      writeReg(1'b1, 1'b0, 16'd1);
      pushExpected("restart_after_write", 32'd6);
      waitTint(50, n);
      checkOutput(n);

      // Coherent read across a divider step
      writeReg(1'b0, 1'b1, 16'h0010);
      writeReg(1'b1, 1'b0, 16'hFFFF);
      repeat (100) tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
      #1;
      pushExpected("coh_pre_read", 32'h0000FF9B);
      checkOutput({16'h0, bus.dout});
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
      repeat (69999) tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
      #1;
      pushExpected("coh_div_held", 32'h00000010);
      checkOutput({16'h0, bus.dout});
      pushExpected("coh_douten", 32'h1);
      checkOutput({31'h0, bus.douten});
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
      #1;
      pushExpected("coh_div_live", 32'h0000000F);
      checkOutput({16'h0, bus.dout});
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);

      // Read mux priority and idle bus
      writeReg(1'b1, 1'b0, 16'd5);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
      #1;
      pushExpected("mux_both_dout", 32'd5);
      checkOutput({16'h0, bus.dout});
      pushExpected("mux_both_douten", 32'h1);
      checkOutput({31'h0, bus.douten});
      tick();
      pushExpected("mux_read_counts_on", 32'd4);
      checkOutput({16'h0, bus.dout});
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
      #1;
      pushExpected("mux_idle_dout", 32'h0);
      checkOutput({16'h0, bus.dout});
      pushExpected("mux_idle_douten", 32'h0);
      checkOutput({31'h0, bus.douten});

      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
